// File: rtl/magia_tile_pkg.sv
// Shared FSYNC constants, FSM state encoding and request-queue entry layout for the MAGIA tile.
package magia_tile_pkg;

  localparam int unsigned FSYNC_AGGR_W = 8;
  localparam int unsigned FSYNC_ID_W   = 8;

  localparam logic [6:0] FSYNC_OPCODE = 7'b1011011;
  localparam logic [2:0] FSYNC_FUNC3  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT,
    ST_DONE
  } fsync_state_e;

  typedef struct packed {
    logic [FSYNC_AGGR_W-1:0] aggr;
    logic [FSYNC_ID_W-1:0]   id;
  } fsync_entry_t;

  function automatic logic is_fsync_opcode(input logic [6:0] opcode);
    return opcode == FSYNC_OPCODE;
  endfunction

endpackage

// File: rtl/fractal_sync_mp_xif_decoder_if.sv
// XIF issue channel plus per-port fractal-sync request/wake bundle.
// slave = decoder side, master = core/fabric side.
interface fractal_sync_mp_xif_decoder_if #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AGGR_W     = magia_tile_pkg::FSYNC_AGGR_W,
  parameter int unsigned ID_W       = magia_tile_pkg::FSYNC_ID_W,
  parameter int unsigned FIFO_DEPTH = 2
);

  logic                               issue_valid_i;
  logic [31:0]                        issue_instr_i;
  logic [1:0][DATA_W-1:0]             issue_rs_i;
  logic                               issue_rs_valid_i;
  logic                               issue_ready_o;
  logic                               issue_accept_o;

  logic [N_PORTS-1:0]                 sync_o;
  logic [N_PORTS-1:0][AGGR_W-1:0]     aggr_o;
  logic [N_PORTS-1:0][ID_W-1:0]       id_req_o;
  logic [N_PORTS-1:0]                 wake_i;
  logic [N_PORTS-1:0]                 error_i;

  logic                               done_o;
  logic                               error_o;
  logic                               busy_o;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    pending_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_rs_i, issue_rs_valid_i,
    output issue_ready_o, issue_accept_o,
    output sync_o, aggr_o, id_req_o,
    input  wake_i, error_i,
    output done_o, error_o, busy_o, pending_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_rs_i, issue_rs_valid_i,
    input  issue_ready_o, issue_accept_o,
    input  sync_o, aggr_o, id_req_o,
    output wake_i, error_i,
    input  done_o, error_o, busy_o, pending_o
  );

endinterface

// File: rtl/fractal_sync_req_fifo.sv
// Circular request FIFO with synchronous flush, full/empty flags and occupancy count.
// Push is dropped when full, pop when empty; flush wins over both.
module fractal_sync_req_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     usage_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_do_push;
  logic                        w_do_pop;

  assign full_o    = (r_cnt == CNT_W'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign usage_o   = r_cnt;
  assign data_o    = r_mem[r_rd_ptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fractal_sync_mp_xif_decoder.sv
// Decodes FSYNC XIF instructions into a request queue and issues them one at a time to a
// tree/neighbour port, waiting for its wake. Optional watchdog: define FSYNC_TIMEOUT_EN.
module fractal_sync_mp_xif_decoder
  import magia_tile_pkg::*;
#(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned AGGR_W         = FSYNC_AGGR_W,
  parameter int unsigned ID_W           = FSYNC_ID_W,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  fractal_sync_mp_xif_decoder_if.slave       xif
);

  localparam int unsigned SEL_W = $clog2(N_PORTS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
  } entry_t;

  fsync_state_e                   r_state;
  logic [SEL_W-1:0]               r_port;
  logic [N_PORTS-1:0]             r_sync;
  logic [N_PORTS-1:0][AGGR_W-1:0] r_aggr;
  logic [N_PORTS-1:0][ID_W-1:0]   r_id;
  logic                           r_done;

  logic             w_op_hit;
  logic             w_f3_hit;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_usage;
  entry_t           w_in;
  entry_t           w_head;
  logic [SEL_W-1:0] w_sel;
  logic             w_wake_hit;
  logic             w_tmo;
  logic             w_unused;

  // Decode is combinational so the core never waits an extra cycle for the handshake.
  assign w_op_hit = xif.issue_valid_i && is_fsync_opcode(xif.issue_instr_i[6:0]);
  assign w_f3_hit = (xif.issue_instr_i[14:12] == FSYNC_FUNC3);
  assign w_push   = w_op_hit && w_f3_hit && xif.issue_rs_valid_i && !w_full && !clear_i;

  assign xif.issue_ready_o  = w_op_hit && (!w_f3_hit || w_push);
  assign xif.issue_accept_o = w_push;

  assign w_in.aggr = xif.issue_rs_i[0][AGGR_W-1:0];
  assign w_in.id   = xif.issue_rs_i[1][ID_W-1:0];
  assign w_pop     = (r_state == ST_SYNC) && !clear_i;

  assign w_unused = ^{xif.issue_instr_i[31:15], xif.issue_instr_i[11:7],
                      xif.issue_rs_i[0][DATA_W-1:AGGR_W], xif.issue_rs_i[1][DATA_W-1:ID_W]};

  fractal_sync_req_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_push),
    .data_i  (w_in),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (w_usage)
  );

  // aggr == 1 addresses a neighbour directly; any other level rides the H/V tree on id[0].
  always_comb begin
    w_sel = '0;
    if (w_head.aggr == AGGR_W'(1)) begin
      w_sel = w_head.id[SEL_W-1:0];
    end else begin
      w_sel = SEL_W'(w_head.id[0]);
    end
  end

  assign w_wake_hit = xif.wake_i[r_port];

`ifdef FSYNC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo_cnt;

  assign w_tmo = (r_state == ST_WAIT) && !w_wake_hit &&
                 (r_tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (clear_i || (r_state != ST_WAIT)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
    end
  end
`else
  logic [TIMEOUT_W-1:0] w_unused_tmo;

  assign w_unused_tmo = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign w_tmo        = 1'b0;
`endif

  // Port outputs are loaded in IDLE so the request appears exactly while the FSM sits in SYNC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_port  <= '0;
      r_sync  <= '0;
      r_aggr  <= '0;
      r_id    <= '0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
      r_sync  <= '0;
      r_aggr  <= '0;
      r_id    <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state        <= ST_SYNC;
            r_sync         <= N_PORTS'(1) << w_sel;
            r_aggr[w_sel]  <= w_head.aggr;
            r_id[w_sel]    <= w_head.id;
          end
        end
        ST_SYNC: begin
          r_state <= ST_WAIT;
          r_port  <= w_sel;
          r_sync  <= '0;
          r_aggr  <= '0;
          r_id    <= '0;
        end
        ST_WAIT: begin
          if (w_wake_hit || w_tmo) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign xif.sync_o    = r_sync;
  assign xif.aggr_o    = r_aggr;
  assign xif.id_req_o  = r_id;
  assign xif.done_o    = r_done;
  assign xif.error_o   = (|xif.error_i) || w_tmo;
  assign xif.busy_o    = (r_state != ST_IDLE) || !w_empty;
  assign xif.pending_o = w_usage;

endmodule

// File: tb/tb_fractal_sync_mp_xif_decoder.sv
// Randomised + directed bench for fractal_sync_mp_xif_decoder against a queue-based reference model.
module tb_fractal_sync_mp_xif_decoder;
  import magia_tile_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 2;
  localparam int TC    = 8;
  localparam int PH_IDLE = 0, PH_SYNC = 1, PH_WAIT = 2, PH_DONE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  fractal_sync_mp_xif_decoder_if #(
    .N_PORTS(NP), .DATA_W(32), .AGGR_W(8), .ID_W(8), .FIFO_DEPTH(DEPTH)
  ) xif ();

  fractal_sync_mp_xif_decoder #(
    .N_PORTS(NP), .DATA_W(32), .AGGR_W(8), .ID_W(8), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_W(16), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .xif     (xif)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] aggr;
    logic [7:0] id;
  } ent_t;

  ent_t mq[$];
  ent_t cur;
  int   ph       = PH_IDLE;
  int   cur_port = 0;
  int   wcnt     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int port_of(input ent_t e);
    if (e.aggr == 8'd1) return int'(e.id[1:0]);
    return int'(e.id[0]);
  endfunction

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0]   = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Reference model: queue of pending syncs plus the phase of the one in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      logic op_hit, f3_hit, acc, rdy, tmo;
      logic [NP-1:0]      e_sync;
      logic [NP-1:0][7:0] e_aggr, e_id;
      ent_t nw;

      op_hit = xif.issue_valid_i && (xif.issue_instr_i[6:0] == FSYNC_OPCODE);
      f3_hit = (xif.issue_instr_i[14:12] == FSYNC_FUNC3);
      acc    = op_hit && f3_hit && xif.issue_rs_valid_i && (mq.size() < DEPTH) && !clear;
      rdy    = op_hit && (!f3_hit || acc);
      e_sync = '0;
      e_aggr = '0;
      e_id   = '0;
      if (ph == PH_SYNC) begin
        e_sync[cur_port] = 1'b1;
        e_aggr[cur_port] = cur.aggr;
        e_id[cur_port]   = cur.id;
      end
      tmo = 1'b0;
`ifdef FSYNC_TIMEOUT_EN
      if (ph == PH_WAIT && wcnt == TC - 1 && !xif.wake_i[cur_port]) tmo = 1'b1;
`endif
      chk("ready",   64'(xif.issue_ready_o),  64'(rdy));
      chk("accept",  64'(xif.issue_accept_o), 64'(acc));
      chk("sync",    64'(xif.sync_o),         64'(e_sync));
      chk("aggr",    64'(xif.aggr_o),         64'(e_aggr));
      chk("id_req",  64'(xif.id_req_o),       64'(e_id));
      chk("done",    64'(xif.done_o),         64'(ph == PH_DONE));
      chk("error",   64'(xif.error_o),        64'((|xif.error_i) || tmo));
      chk("busy",    64'(xif.busy_o),         64'(ph != PH_IDLE || mq.size() != 0));
      chk("pending", 64'(xif.pending_o),      64'(mq.size()));

      nw.aggr = xif.issue_rs_i[0][7:0];
      nw.id   = xif.issue_rs_i[1][7:0];
      if (clear) begin
        mq.delete();
        ph = PH_IDLE;
      end else begin
        case (ph)
          PH_IDLE: if (mq.size() > 0) begin
            cur      = mq[0];
            cur_port = port_of(cur);
            ph       = PH_SYNC;
          end
          PH_SYNC: begin
            void'(mq.pop_front());
            wcnt = 0;
            ph   = PH_WAIT;
          end
          PH_WAIT: if (xif.wake_i[cur_port] || tmo) ph = PH_DONE;
                   else wcnt++;
          default: ph = PH_IDLE;
        endcase
        if (acc) mq.push_back(nw);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    xif.issue_valid_i    = 1'b0;
    xif.issue_instr_i    = '0;
    xif.issue_rs_i       = '0;
    xif.issue_rs_valid_i = 1'b0;
    xif.wake_i           = '0;
    xif.error_i          = '0;
    clear                = 1'b0;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [7:0] aggr, input logic [7:0] id);
    xif.issue_valid_i    = 1'b1;
    xif.issue_instr_i    = mk_instr(opc, f3);
    xif.issue_rs_i[0]    = {24'h0, aggr};
    xif.issue_rs_i[1]    = {24'h0, id};
    xif.issue_rs_valid_i = 1'b1;
  endtask

  initial begin
    quiet();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sync",    64'(xif.sync_o),    64'h0);
    chk("rst_done",    64'(xif.done_o),    64'h0);
    chk("rst_busy",    64'(xif.busy_o),    64'h0);
    chk("rst_pending", 64'(xif.pending_o), 64'h0);
    chk("rst_aggr",    64'(xif.aggr_o),    64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single tree sync: aggr 2, id 1 -> port 1.
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd2, 8'd1);
    @(negedge clk); chk("s1_accept", 64'(xif.issue_accept_o), 64'h1);
    tick(); quiet();
    @(negedge clk); chk("s1_pending", 64'(xif.pending_o), 64'h1);
    tick();
    @(negedge clk); chk("s1_sync", 64'(xif.sync_o), 64'h2);
    chk("s1_aggr1", 64'(xif.aggr_o[1]), 64'h2);
    chk("s1_id1",   64'(xif.id_req_o[1]), 64'h1);
    tick(); tick();
    tick(); xif.wake_i = 4'b0010;
    @(negedge clk); chk("s1_nodone", 64'(xif.done_o), 64'h0);
    tick(); xif.wake_i = '0;
    @(negedge clk); chk("s1_done", 64'(xif.done_o), 64'h1);
    tick();
    @(negedge clk); chk("s1_idle", 64'(xif.busy_o), 64'h0);

    // Neighbour sync: aggr 1, id 3 -> port 3 only; wake on port 2 is ignored.
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd1, 8'd3);
    tick(); quiet();
    tick();
    @(negedge clk); chk("s2_sync", 64'(xif.sync_o), 64'h8);
    tick(); xif.wake_i = 4'b0100;
    tick(); xif.wake_i = '0;
    @(negedge clk); chk("s2_ignored", 64'(xif.done_o), 64'h0);
    tick(); xif.wake_i = 4'b1000;
    tick(); xif.wake_i = '0;
    @(negedge clk); chk("s2_done", 64'(xif.done_o), 64'h1);
    repeat (2) tick();

    // Queue full, then clear while waiting with one entry queued.
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd2, 8'd0);
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd2, 8'd0);
    @(negedge clk); chk("s3_acc2", 64'(xif.issue_accept_o), 64'h1);
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd2, 8'd0);
    @(negedge clk); chk("s3_full_rdy", 64'(xif.issue_ready_o), 64'h0);
    chk("s3_pending2", 64'(xif.pending_o), 64'h2);
    tick();
    @(negedge clk); chk("s3_rdy_after_pop", 64'(xif.issue_ready_o), 64'h1);
    tick(); quiet(); xif.wake_i = 4'b0001;
    tick(); xif.wake_i = '0;
    @(negedge clk); chk("s3_done", 64'(xif.done_o), 64'h1);
    tick(); tick();
    tick(); clear = 1'b1;
    @(negedge clk); chk("s3_pend_before_clr", 64'(xif.pending_o), 64'h1);
    tick(); clear = 1'b0;
    @(negedge clk); chk("s3_clr_pending", 64'(xif.pending_o), 64'h0);
    chk("s3_clr_busy", 64'(xif.busy_o), 64'h0);
    chk("s3_clr_done", 64'(xif.done_o), 64'h0);

    // Foreign opcode and bad func3.
    tick(); issue(7'h0B, FSYNC_FUNC3, 8'd2, 8'd0);
    @(negedge clk); chk("s4_foreign_rdy", 64'(xif.issue_ready_o), 64'h0);
    chk("s4_foreign_acc", 64'(xif.issue_accept_o), 64'h0);
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3 ^ 3'b111, 8'd2, 8'd0);
    @(negedge clk); chk("s4_badf3_rdy", 64'(xif.issue_ready_o), 64'h1);
    chk("s4_badf3_acc", 64'(xif.issue_accept_o), 64'h0);
    tick(); quiet();
    @(negedge clk); chk("s4_pending", 64'(xif.pending_o), 64'h0);

`ifdef FSYNC_TIMEOUT_EN
    // No wake: error pulse on the 8th WAIT cycle, done the cycle after.
    tick(); issue(FSYNC_OPCODE, FSYNC_FUNC3, 8'd2, 8'd0);
    tick(); quiet();
    repeat (9) tick();
    @(negedge clk); chk("tmo_err", 64'(xif.error_o), 64'h1);
    chk("tmo_nodone", 64'(xif.done_o), 64'h0);
    tick();
    @(negedge clk); chk("tmo_done", 64'(xif.done_o), 64'h1);
    chk("tmo_err_gone", 64'(xif.error_o), 64'h0);
`endif
    repeat (2) tick();

    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [6:0] opc;
      logic [2:0] f3;
      tick();
      r   = $urandom_range(0, 99);
      opc = (r < 85) ? FSYNC_OPCODE : 7'h0B;
      f3  = (r >= 70 && r < 85) ? (FSYNC_FUNC3 ^ 3'($urandom_range(1, 7))) : FSYNC_FUNC3;
      xif.issue_valid_i    = 1'($urandom_range(0, 1));
      xif.issue_instr_i    = mk_instr(opc, f3);
      xif.issue_rs_i[0]    = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
      xif.issue_rs_i[1]    = $urandom;
      xif.issue_rs_valid_i = ($urandom_range(0, 9) != 0);
      xif.wake_i           = 4'($urandom) & 4'($urandom);
      xif.error_i          = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      clear                = ($urandom_range(0, 49) == 0);
    end

    tick(); quiet();
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
